// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator producing a pixel clock enable,
// sync/blank/active decode, X/Y counters, line/frame strobes and a line-compare pulse.
module vga_timing_gen #(
  parameter int H_DISPLAY  = 800,
  parameter int H_FRONT    = 56,
  parameter int H_SYNC     = 120,
  parameter int H_BACK     = 64,
  parameter int V_DISPLAY  = 600,
  parameter int V_FRONT    = 37,
  parameter int V_SYNC     = 6,
  parameter int V_BACK     = 23,
  parameter bit HSYNC_POL  = 1'b1,
  parameter bit VSYNC_POL  = 1'b1,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 0,
  parameter int X_W        = 11,
  parameter int Y_W        = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  input  logic [Y_W-1:0] cmp_line,
  output logic           pix_ce,
  output logic [X_W-1:0] counter_x,
  output logic [Y_W-1:0] counter_y,
  output logic           hsync,
  output logic           vsync,
  output logic           display_active,
  output logic           hblank,
  output logic           vblank,
  output logic           line_start,
  output logic           frame_start,
  output logic           line_irq
);

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Flag vector order {hsync, vsync, display_active, hblank, vblank}, all active-high.
  function automatic logic [4:0] decode_flags(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    logic hs, vs, hb, vb;
    hs = (x >= X_W'(HS_START)) && (x < X_W'(HS_END));
    vs = (y >= Y_W'(VS_START)) && (y < Y_W'(VS_END));
    hb = (x >= X_W'(H_DISPLAY));
    vb = (y >= Y_W'(V_DISPLAY));
    return {hs, vs, ~hb & ~vb, hb, vb};
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;
  logic             x_last;
  logic             y_last;
  logic [X_W-1:0]   x_nxt;
  logic [Y_W-1:0]   y_nxt;
  logic             started;
  logic             new_line;
  logic [4:0]       flags_p0;
  logic [4:0]       flags_out;

  // Free-running divider; pix_ce is the registered wrap
  assign div_wrap = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pix_ce  <= 1'b0;
    end else begin
      pix_ce  <= div_wrap;
      div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
    end
  end

  assign x_last = (counter_x == X_W'(H_TOTAL - 1));
  assign y_last = (counter_y == Y_W'(V_TOTAL - 1));

  always_comb begin
    x_nxt = counter_x + X_W'(1);
    y_nxt = counter_y;
    if (x_last) begin
      x_nxt = '0;
      y_nxt = y_last ? '0 : counter_y + Y_W'(1);
    end
  end

  // The first tick after a stop or reset counts as the start of line 0 of a new frame.
  assign new_line = (x_nxt == '0) || !started;

  // Stage p0: counters, strobes and undelayed flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_x   <= '0;
      counter_y   <= '0;
      started     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      line_irq    <= 1'b0;
      flags_p0    <= '0;
    end else if (!enable) begin
      counter_x   <= '0;
      counter_y   <= '0;
      started     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      line_irq    <= 1'b0;
      flags_p0    <= '0;
    end else if (pix_ce) begin
      counter_x   <= x_nxt;
      counter_y   <= y_nxt;
      started     <= 1'b1;
      line_start  <= new_line;
      frame_start <= new_line && (y_nxt == '0);
      line_irq    <= new_line && (y_nxt == cmp_line);
      flags_p0    <= decode_flags(x_nxt, y_nxt);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      line_irq    <= 1'b0;
    end
  end

  // Stages p1..pN: flag delay line advanced on pixel ticks
  generate
    if (PIPE_DELAY == 0) begin : g_no_dly
      assign flags_out = flags_p0;
    end else begin : g_dly
      logic [4:0] dly_p1 [PIPE_DELAY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_DELAY; i++) dly_p1[i] <= '0;
        end else if (!enable) begin
          for (int i = 0; i < PIPE_DELAY; i++) dly_p1[i] <= '0;
        end else if (pix_ce) begin
          dly_p1[0] <= flags_p0;
          for (int i = 1; i < PIPE_DELAY; i++) dly_p1[i] <= dly_p1[i-1];
        end
      end

      assign flags_out = dly_p1[PIPE_DELAY-1];
    end
  endgenerate

  assign hsync          = flags_out[4] ? HSYNC_POL : ~HSYNC_POL;
  assign vsync          = flags_out[3] ? VSYNC_POL : ~VSYNC_POL;
  assign display_active = flags_out[2];
  assign hblank         = flags_out[1];
  assign vblank         = flags_out[0];

endmodule
